// File: rtl/rotary_quadrature_driver_pkg.sv
// rotary_quadrature_driver_pkg: shared state encoding, dir codes and A/B phase map
package rotary_quadrature_driver_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PH_A    = 3'd2,
    PH_AB   = 3'd3,
    PH_B    = 3'd4,
    RELEASE = 3'd5
  } state_t;
  localparam logic [1:0] DIR_POS_X = 2'b00;
  localparam logic [1:0] DIR_NEG_X = 2'b01;
  localparam logic [1:0] DIR_NEG_Y = 2'b10;
  localparam logic [1:0] DIR_POS_Y = 2'b11;
  function automatic logic [1:0] ab_of(input state_t s);
    return s == PH_A ? 2'b10 : s == PH_AB ? 2'b11 : s == PH_B ? 2'b01 : 2'b00;
  endfunction
endpackage

// File: rtl/rotary_quadrature_driver_cmd_fifo.sv
// rotary_quadrature_driver_cmd_fifo: sync command queue, push+pop legal at any occupancy
module rotary_quadrature_driver_cmd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign dout = mem[rptr];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // pointer and occupancy update; a pop frees the slot a same-cycle push uses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= do_push ? wptr + AW'(1) : wptr;
      rptr <= do_pop ? rptr + AW'(1) : rptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/rotary_quadrature_driver.sv
// rotary_quadrature_driver: plays each queued move command as one quadrature detent
module rotary_quadrature_driver
  import rotary_quadrature_driver_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = $clog2(PHASE_CYCLES + 1),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_data,
  output logic       cmd_ready,
  output logic [3:0] inp,
  output logic       ROT_A,
  output logic       ROT_B,
  output logic       busy,
  output logic       done
);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0] head;
  logic [CW-1:0] count;
  logic full, empty, pop, last;
  rotary_quadrature_driver_cmd_fifo #(.WIDTH(4), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(cmd_valid && cmd_ready),
    .pop(pop),
    .din(cmd_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign cmd_ready = !full || pop;
  assign busy = state != IDLE;
  // next state: pop from IDLE or at the end of RELEASE, else step phases on counter expiry
  always_comb begin
    last = cnt == CNT_W'(1);
    pop = !empty && (state == IDLE || (state == RELEASE && last));
    nxt = pop ? SETUP : (state == IDLE || !last) ? state : state == RELEASE ? IDLE : state_t'(state + 3'd1);
  end
  // occupancy can never exceed the queue depth
  always_comb assert (count <= CW'(FIFO_DEPTH));
  // FSM, phase counter and registered outputs; A/B follow the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      inp <= '0;
      {ROT_A, ROT_B} <= 2'b00;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? CNT_W'(PHASE_CYCLES) : state == IDLE ? cnt : cnt - CNT_W'(1);
      inp <= pop ? head : inp;
      {ROT_A, ROT_B} <= ab_of(nxt);
      done <= state == RELEASE && last;
    end
  end
endmodule

// File: tb/tb_rotary_quadrature_driver.sv
// tb_rotary_quadrature_driver: scoreboard bench for the quadrature detent driver
module tb_rotary_quadrature_driver;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [3:0] cmd_data = 4'd0;
  logic cmd_ready, rot_a, rot_b, busy, done;
  logic [3:0] inp;
  logic v1 = 1'b0;
  logic [3:0] d1 = 4'd0;
  logic r1, a1, b1, busy1, done1;
  logic [3:0] inp1;
  int total = 0;
  int bad = 0;
  logic [3:0] q[$];
  int pos = -1;
  logic [3:0] cur = 4'd0;
  logic [3:0] last_inp = 4'd0;
  logic [1:0] pat [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};

  rotary_quadrature_driver #(.PHASE_CYCLES(P), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .inp(inp), .ROT_A(rot_a), .ROT_B(rot_b),
    .busy(busy), .done(done)
  );

  rotary_quadrature_driver #(.PHASE_CYCLES(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_data(d1),
    .cmd_ready(r1), .inp(inp1), .ROT_A(a1), .ROT_B(b1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard monitor: each detent pops one expected command and checks its trace
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ab", {rot_a, rot_b}, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_inp", inp, 4'd0);
      q.delete();
      pos = -1;
      last_inp = 4'd0;
    end else begin
      if (pos >= 0) pos++;
      check("done", done, pos == 5 * P);
      if (pos < 0 || pos == 5 * P) begin
        if (busy) begin
          if (q.size() == 0) begin
            check("underflow", 1'b1, 1'b0);
            cur = last_inp;
          end else cur = q.pop_front();
          pos = 0;
          last_inp = cur;
        end else pos = -1;
      end
      if (pos >= 0) begin
        check("inp", inp, cur);
        check("ab", {rot_a, rot_b}, pat[pos / P]);
        check("busy", busy, 1'b1);
      end else begin
        check("idle_inp", inp, last_inp);
        check("idle_ab", {rot_a, rot_b}, 2'b00);
      end
    end
  end

  task automatic push(input logic [3:0] d, input logic exp_ready);
    int n = 0;
    logic first = 1'b1;
    @(negedge clk);
    #1 cmd_valid = 1'b1;
    cmd_data = d;
    forever begin
      #3;
      if (first) begin
        check("ready_first", cmd_ready, exp_ready);
        first = 1'b0;
      end
      if (cmd_ready) begin
        q.push_back(d);
        @(posedge clk);
        break;
      end
      if (++n > 100) begin
        check("push_timeout", 1'b0, 1'b1);
        @(posedge clk);
        break;
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      #1;
      if (!busy && q.size() == 0 && pos < 0) return;
    end
    check("idle_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);
    // single detent with explicit latency check
    push(4'b0100, 1'b1);
    @(negedge clk);
    check("lat_busy0", busy, 1'b0);
    @(negedge clk);
    check("lat_busy1", busy, 1'b1);
    check("lat_inp", inp, 4'b0100);
    wait_idle();
    // fill the queue, then a held offer lands on the RELEASE pop
    push(4'b0100, 1'b1);
    push(4'b1101, 1'b1);
    push(4'b1010, 1'b1);
    push(4'b0011, 1'b1);
    push(4'b0110, 1'b1);
    push(4'b1001, 1'b0);
    @(negedge clk);
    #4 check("still_full", cmd_ready, 1'b0);
    wait_idle();
    // reset in PH_AB with three commands queued
    push(4'b0001, 1'b1);
    push(4'b0010, 1'b1);
    push(4'b0111, 1'b1);
    push(4'b1011, 1'b1);
    begin
      int n = 0;
      while (!(rot_a && rot_b) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("reach_ph_ab", {rot_a, rot_b}, 2'b11);
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ab", {rot_a, rot_b}, 2'b00);
    check("mid_rst_ready", cmd_ready, 1'b1);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("flushed_busy", busy, 1'b0);
    // single-cycle phases on the second instance
    check("p1_ready", r1, 1'b1);
    #1 v1 = 1'b1;
    d1 = 4'b1111;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    check("p1_lat", busy1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("p1_ab", {a1, b1}, pat[i]);
      check("p1_inp", inp1, 4'b1111);
      check("p1_done0", done1, 1'b0);
    end
    @(negedge clk);
    check("p1_done", done1, 1'b1);
    check("p1_idle", busy1, 1'b0);
    @(negedge clk);
    check("p1_done_pulse", done1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
